mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 64 kB main-memory port between I-cache miss fills and D-cache reads/writes.
//  Sits between both L1 caches and main memory and serves one transaction at a time.
//  Adds a per-transaction watchdog so a hung memory cannot stall the CPU.
// PARAMETERS
//  TIMEOUT   255   max cycles in BUSY without mem_ack before abort; 8-bit counter, legal 1..255
//  ERR_DATA  32'hDEAD_BEEF   data returned to the requester on timeout
// PORTS
//  clk       in   1   single clock, all state on rising edge
//  reset     in   1   asynchronous, active-low; clears all state immediately
//  ic_addr   in   16  I-cache miss address
//  ic_en     in   1   I-cache request, level, held until ic_ack
//  ic_ack    out  1   one-cycle pulse, ic_do valid this cycle
//  ic_do     out  32  read data to I-cache
//  dc_addr   in   16  D-cache address
//  dc_en     in   1   D-cache request, level, held until dc_ack
//  dc_we     in   1   1 = write, 0 = read; valid while dc_en
//  dc_di     in   32  D-cache write data
//  dc_ack    out  1   one-cycle pulse, dc_do valid this cycle
//  dc_do     out  32  read data to D-cache (value undefined on writes)
//  mem_addr  out  16  main-memory address, registered
//  mem_en    out  1   main-memory request, held until mem_ack or timeout
//  mem_we    out  1   main-memory write enable
//  mem_di    out  32  main-memory write data
//  mem_ack   in   1   main-memory completion, single-cycle pulse
//  mem_do    in   32  main-memory read data, valid with mem_ack
//  err       out  1   one-cycle pulse with the requester ack on timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_grant=DC so the I-cache wins the first tie; timer=0.
//  IDLE: with no en, stay. With one en, grant it. On edge N, latch addr/we/di into mem_*.
//    mem_en=1 from N; mem_we=0 for I-cache; timer=0; -> BUSY.
//  BUSY: on a cycle with mem_ack at edge M, mem_en<=0.
//    Load the granted *_do with mem_do and set the granted *_ack=1; -> RESP.
//    Without mem_ack: timer++. If timer==TIMEOUT-1: mem_en<=0, *_do<=ERR_DATA, *_ack<=1, err<=1; -> RESP.
//  RESP: acks and err held for exactly one cycle, then cleared; -> IDLE.
//    en is ignored in RESP; the requester drops en at the edge that samples its ack.
//  Latency: en seen at edge N -> mem_en high after N; mem_ack at M -> requester ack high after M.
//    Minimum 3 cycles from request to ack.
//  Only the granted requester's ack ever pulses. The non-granted requester waits with en held.
//  mem_ack in IDLE or RESP is ignored: no ack, no state change.
//  Request-side inputs are sampled only in IDLE; changes during BUSY have no effect.
//  Reset low mid-transaction: mem_en/acks drop at once, state IDLE, the pending request is lost.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: on tie in IDLE grant the requester != last_grant.
//    last_grant updates on every grant.
//  Not defined: fixed priority, D-cache always wins a tie; last_grant unused (may be optimised away).
// STRUCTURE
//  Package tinycpu_mem_pkg: ADDR_W=16, DATA_W=32, state enum {IDLE,BUSY,RESP}.
//    Also the requester id enum {IC,DC} and the ERR_DATA default.
//  No sub-module; picker and timer stay inline, one always block per register group.
// TESTING
//  I-cache read alone, mem_ack 4 cycles after mem_en -> mem_addr=ic_addr, mem_we=0.
//    ic_ack one cycle with ic_do=mem_do; dc_ack stays 0.
//  D-cache write 0x1234 data 0xCAFEF00D -> mem_we=1, mem_di=0xCAFEF00D, mem_addr=0x1234.
//    dc_ack one cycle after mem_ack.
//  Both en on the same edge, no RR -> DC served first, then IC.
//    With MEM_ARB_ROUND_ROBIN_EN after reset: IC, then DC; repeat -> strict alternation.
//  mem_ack never arrives, TIMEOUT=8 -> mem_en drops after 8 BUSY cycles.
//    Granted ack=1, err=1, do=0xDEADBEEF, next request served normally.
//  reset low 2 cycles into BUSY -> mem_en=0 asynchronously, all outputs 0.
//    After release, IC wins the first tie.
//  Spurious mem_ack in IDLE -> no ack pulse, state stays IDLE.

Source files
------------

// File: rtl/tinycpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tinycpu_mem_pkg
// Description : Shared widths, arbiter state encoding, requester ids and the
//               default error word for the main-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tinycpu_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    // Word handed back to a requester whose transaction was aborted
    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single main-memory port between I-cache miss fills
//               and D-cache reads/writes, one transaction at a time, with a
//               per-transaction watchdog that aborts a hung memory access.
//               Optional macro MEM_ARB_ROUND_ROBIN_EN: on a tie the requester
//               not granted last time wins; otherwise the D-cache always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import tinycpu_mem_pkg::*;
#(
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    // I-cache side
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_en,
    output logic              ic_ack,
    output logic [DATA_W-1:0] ic_do,
    // D-cache side
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_en,
    input  logic              dc_we,
    input  logic [DATA_W-1:0] dc_di,
    output logic              dc_ack,
    output logic [DATA_W-1:0] dc_do,
    // Main-memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_di,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_do,
    // Watchdog abort indication, pulses together with the requester ack
    output logic              err
);

    // Last timer value reached in BUSY before the watchdog fires
    localparam logic [7:0] C_TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;
    req_id_t    r_grant;
    req_id_t    w_pick;
    logic [7:0] r_timer;
    logic       w_start;
    logic       w_done;
    logic       w_abort;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t    r_last_grant;
`endif

    // Requester selection: a lone request wins outright, a tie uses the policy
    always_comb begin
        w_pick = DC;
        if (ic_en && dc_en) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w_pick = (r_last_grant == DC) ? IC : DC;
`else
            w_pick = DC;
`endif
        end else if (ic_en) begin
            w_pick = IC;
        end
    end

    // Next-state logic and the per-cycle transaction events
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (ic_en || dc_en) begin
                    w_start      = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    w_done       = 1'b1;
                    w_next_state = RESP;
                end else if (r_timer == C_TIMER_LAST) begin
                    w_abort      = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Remember who owns the current transaction (and who went last for ties)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant      <= IC;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_grant <= DC;
`endif
        end else if (w_start) begin
            r_grant      <= w_pick;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_grant <= w_pick;
`endif
        end
    end

    // Watchdog: counts BUSY cycles spent waiting for mem_ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= 8'd0;
        end else if (w_start) begin
            r_timer <= 8'd0;
        end else if (r_state == BUSY && !mem_ack) begin
            r_timer <= r_timer + 8'd1;
        end
    end

    // Memory port: latch the winning request, hold mem_en until ack or abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr <= '0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_di   <= '0;
        end else if (w_start) begin
            mem_en <= 1'b1;
            if (w_pick == DC) begin
                mem_addr <= dc_addr;
                mem_we   <= dc_we;
                mem_di   <= dc_di;
            end else begin
                mem_addr <= ic_addr;
                mem_we   <= 1'b0;
                mem_di   <= '0;
            end
        end else if (w_done || w_abort) begin
            mem_en <= 1'b0;
        end
    end

    // Requester responses: one-cycle ack (and err on abort) to the owner only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ic_ack <= 1'b0;
            dc_ack <= 1'b0;
            ic_do  <= '0;
            dc_do  <= '0;
            err    <= 1'b0;
        end else if (w_done || w_abort) begin
            err <= w_abort;
            if (r_grant == DC) begin
                dc_ack <= 1'b1;
                dc_do  <= w_abort ? ERR_DATA : mem_do;
            end else begin
                ic_ack <= 1'b1;
                ic_do  <= w_abort ? ERR_DATA : mem_do;
            end
        end else begin
            ic_ack <= 1'b0;
            dc_ack <= 1'b0;
            err    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed transactions
//               followed by randomized requests and memory latencies, checked
//               against a transaction-level arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import tinycpu_mem_pkg::*;

    localparam int          TO      = 8;
    localparam logic [31:0] ERR_EXP = 32'hDEAD_BEEF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit          RR      = 1'b1;
`else
    localparam bit          RR      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ic_addr = '0;
    logic        ic_en = 1'b0;
    logic        ic_ack;
    logic [31:0] ic_do;
    logic [15:0] dc_addr = '0;
    logic        dc_en = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_di = '0;
    logic        dc_ack;
    logic [31:0] dc_do;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_di;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_do = '0;
    logic        err;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ic_addr(ic_addr), .ic_en(ic_en), .ic_ack(ic_ack), .ic_do(ic_do),
        .dc_addr(dc_addr), .dc_en(dc_en), .dc_we(dc_we), .dc_di(dc_di),
        .dc_ack(dc_ack), .dc_do(dc_do),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_di(mem_di),
        .mem_ack(mem_ack), .mem_do(mem_do), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Requester-side model: what each cache is currently asking for
    bit          ic_pend = 1'b0;
    bit          dc_pend = 1'b0;
    logic [15:0] ic_a = '0;
    logic [15:0] dc_a = '0;
    bit          dc_w = 1'b0;
    logic [31:0] dc_d = '0;
    bit          last_dc = 1'b1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req_ic(input logic [15:0] a);
        ic_pend = 1'b1;
        ic_a    = a;
        ic_addr = a;
        ic_en   = 1'b1;
    endtask

    task automatic req_dc(input logic [15:0] a, input bit w, input logic [31:0] d);
        dc_pend = 1'b1;
        dc_a    = a;
        dc_w    = w;
        dc_d    = d;
        dc_addr = a;
        dc_we   = w;
        dc_di   = d;
        dc_en   = 1'b1;
    endtask

    // Request-side wiggling while BUSY; must not disturb the transaction
    task automatic scramble;
        ic_addr = 16'($urandom);
        dc_addr = 16'($urandom);
        dc_di   = $urandom;
        dc_we   = 1'($urandom);
        ic_en   = 1'($urandom);
        dc_en   = 1'($urandom);
    endtask

    task automatic restore;
        ic_en   = ic_pend;
        ic_addr = ic_a;
        dc_en   = dc_pend;
        dc_addr = dc_a;
        dc_we   = dc_w;
        dc_di   = dc_d;
    endtask

    // One full transaction from IDLE; delay 0 means memory never answers
    task automatic serve(input int delay);
        bit          g_dc;
        bit          ew;
        bit          exp_err;
        logic [15:0] ea;
        logic [31:0] ed;
        logic [31:0] rd;
        if (ic_pend && dc_pend) g_dc = RR ? !last_dc : 1'b1;
        else                    g_dc = dc_pend;
        last_dc = g_dc;
        ea = g_dc ? dc_a : ic_a;
        ew = g_dc && dc_w;
        ed = dc_d;
        tick;
        check("grant_mem_en", 32'(mem_en), 32'd1);
        check("grant_mem_addr", 32'(mem_addr), 32'(ea));
        check("grant_mem_we", 32'(mem_we), 32'(ew));
        if (ew) check("grant_mem_di", mem_di, ed);
        scramble();
        if (delay == 0) begin
            for (int i = 1; i < TO; i++) begin
                tick;
                check("wd_mem_en_hold", 32'(mem_en), 32'd1);
                check("wd_no_ack", {30'd0, ic_ack, dc_ack}, 32'd0);
                scramble();
            end
            tick;
            rd      = ERR_EXP;
            exp_err = 1'b1;
        end else begin
            for (int i = 1; i < delay; i++) begin
                tick;
                check("busy_mem_addr", 32'(mem_addr), 32'(ea));
                check("busy_no_ack", {29'd0, ic_ack, dc_ack, err}, 32'd0);
                scramble();
            end
            rd      = $urandom;
            mem_do  = rd;
            mem_ack = 1'b1;
            tick;
            mem_ack = 1'b0;
            mem_do  = $urandom;
            exp_err = 1'b0;
        end
        check("done_mem_en", 32'(mem_en), 32'd0);
        check("ic_ack", 32'(ic_ack), 32'(!g_dc));
        check("dc_ack", 32'(dc_ack), 32'(g_dc));
        check("err", 32'(err), 32'(exp_err));
        if (exp_err || !ew) check("rdata", g_dc ? dc_do : ic_do, rd);
        if (g_dc) dc_pend = 1'b0;
        else      ic_pend = 1'b0;
        restore();
        tick;
        check("resp_clear", {29'd0, ic_ack, dc_ack, err}, 32'd0);
        check("idle_mem_en", 32'(mem_en), 32'd0);
    endtask

    initial begin
        // Reset state
        tick;
        check("rst_outputs", {27'd0, mem_en, mem_we, ic_ack, dc_ack, err}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b1;
        tick;

        // I-cache read alone, ack 4 cycles after mem_en
        req_ic(16'h0040);
        serve(4);
        // D-cache write
        req_dc(16'h1234, 1'b1, 32'hCAFE_F00D);
        serve(2);
        // Simultaneous requests
        req_ic(16'h0100);
        req_dc(16'h0200, 1'b0, 32'h0);
        serve(3);
        serve(1);
        // Watchdog abort, then a normal transaction
        req_dc(16'h0300, 1'b0, 32'h0);
        serve(0);
        req_ic(16'h0304);
        serve(1);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            if (!ic_pend && ($urandom % 2 == 0)) req_ic(16'($urandom));
            if (!dc_pend && ($urandom % 2 == 0)) req_dc(16'($urandom), 1'($urandom), $urandom);
            if (!ic_pend && !dc_pend) req_ic(16'($urandom));
            serve(($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 6)));
        end
        while (ic_pend || dc_pend) serve(1);

        // Spurious mem_ack in IDLE
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check("spur_no_ack", {29'd0, ic_ack, dc_ack, err}, 32'd0);
        check("spur_mem_en", 32'(mem_en), 32'd0);
        tick;
        check("spur_still_idle", {28'd0, mem_en, ic_ack, dc_ack, err}, 32'd0);
        req_dc(16'h0400, 1'b0, 32'h0);
        serve(2);

        // Asynchronous reset two cycles into BUSY
        req_ic(16'h0500);
        req_dc(16'h0600, 1'b1, 32'h1111_2222);
        tick;
        tick;
        tick;
        #2;
        reset = 1'b0;
        #1;
        check("arst_ctrl", {27'd0, mem_en, mem_we, ic_ack, dc_ack, err}, 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_di", mem_di, 32'd0);
        check("arst_ic_do", ic_do, 32'd0);
        check("arst_dc_do", dc_do, 32'd0);
        tick;
        tick;
        check("arst_held", {28'd0, mem_en, ic_ack, dc_ack, err}, 32'd0);
        reset = 1'b1;
        last_dc = 1'b1;
        serve(2);
        serve(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
